gcd_stein: RTL and testbench

Parametrised successor to the 8-bit `gcd` block. It computes the greatest common divisor of two unsigned `WIDTH`-bit operands with the binary (Stein) algorithm, one step per clock. It reports an iteration count for performance checks. It sits behind the same start/done handshake as `gcd`, and adds a `busy` output and back-to-back operation. Zero operands are flagged as errors, the same as in `gcd`.

---
 rtl/gcd_pkg.sv | 16 +
 rtl/gcd_step.sv | 39 +++
 rtl/gcd_stein.sv | 116 +++++++++++
 tb/tb_gcd_stein.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and helpers for the binary (Stein) GCD engine.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the iteration counter. The algorithm needs fewer than
  // 4*width steps, so this leaves headroom for the terminal step.
  function automatic int gcd_cnt_w(input int width);
    return $clog2(4 * width + 2);
  endfunction

endpackage

// File: rtl/gcd_step.sv
// One combinational step of the binary GCD reduction.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_ra,
  input  logic [WIDTH-1:0] i_rb,
  output logic [WIDTH-1:0] o_raNext,
  output logic [WIDTH-1:0] o_rbNext,
  output logic             o_kInc,
  output logic             o_eq
);

  // Pick the highest-priority reduction; the larger operand is always the minuend.
  always_comb begin
    o_raNext = i_ra;
    o_rbNext = i_rb;
    o_kInc   = 1'b0;
    o_eq     = (i_ra == i_rb);
    if (o_eq) begin
      o_raNext = i_ra;
      o_rbNext = i_rb;
    end else if (!i_ra[0] && !i_rb[0]) begin
      o_raNext = i_ra >> 1;
      o_rbNext = i_rb >> 1;
      o_kInc   = 1'b1;
    end else if (!i_ra[0]) begin
      o_raNext = i_ra >> 1;
    end else if (!i_rb[0]) begin
      o_rbNext = i_rb >> 1;
    end else if (i_ra > i_rb) begin
      o_raNext = i_ra - i_rb;
    end else begin
      o_rbNext = i_rb - i_ra;
    end
  end

endmodule

// File: rtl/gcd_stein.sv
// Binary GCD engine with start/done handshake, busy flag and iteration count.
module gcd_stein
  import gcd_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = gcd_cnt_w(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y,
  output logic             o_done,
  output logic             o_error,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_iter
);

  localparam int K_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_stateNext;
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic [K_W-1:0]   r_k;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_y;
  logic             r_error;
  logic [CNT_W-1:0] r_iter;

  logic [WIDTH-1:0] w_raNext;
  logic [WIDTH-1:0] w_rbNext;
  logic             w_kInc;
  logic             w_eq;
  logic             w_accept;
  logic             w_zeroOp;
  logic [CNT_W-1:0] w_cntInc;

  gcd_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_ra    (r_ra),
    .i_rb    (r_rb),
    .o_raNext(w_raNext),
    .o_rbNext(w_rbNext),
    .o_kInc  (w_kInc),
    .o_eq    (w_eq)
  );

  assign w_accept = i_start && ((r_state == IDLE) || (r_state == DONE));
  assign w_zeroOp = (i_a == '0) || (i_b == '0);
  assign w_cntInc = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_W'(1);

  // State register; a new request is only taken from IDLE or DONE.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  // Next-state logic; zero operands skip CALC and finish immediately.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: if (w_accept) w_stateNext = w_zeroOp ? DONE : CALC;
      CALC: if (w_eq)     w_stateNext = DONE;
      DONE: begin
        if (w_accept) w_stateNext = w_zeroOp ? DONE : CALC;
        else          w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Operand, shift, counter and result registers; results hold until overwritten.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ra    <= '0;
      r_rb    <= '0;
      r_k     <= '0;
      r_cnt   <= '0;
      r_y     <= '0;
      r_error <= 1'b0;
      r_iter  <= '0;
    end else if (w_accept) begin
      r_ra  <= i_a;
      r_rb  <= i_b;
      r_k   <= '0;
      r_cnt <= '0;
      if (w_zeroOp) begin
        r_y     <= '0;
        r_error <= 1'b1;
        r_iter  <= '0;
      end
    end else if (r_state == CALC) begin
      if (w_eq) begin
        r_y     <= r_ra << r_k;
        r_error <= 1'b0;
        r_iter  <= w_cntInc;
      end else begin
        r_ra  <= w_raNext;
        r_rb  <= w_rbNext;
        r_k   <= r_k + K_W'(w_kInc);
        r_cnt <= w_cntInc;
      end
    end
  end

  assign o_y     = r_y;
  assign o_error = r_error;
  assign o_iter  = r_iter;
  assign o_done  = (r_state == DONE);
  assign o_busy  = (r_state == CALC);

endmodule

// File: tb/tb_gcd_stein.sv
// Directed bench for gcd_stein at WIDTH=8 and WIDTH=16.
module tb_gcd_stein;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, y8;
  logic        done8, error8, busy8;
  logic [5:0]  iter8;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, y16;
  logic        done16, error16, busy16;
  logic [6:0]  iter16;

  int assertCount = 0;
  int failCount   = 0;

  gcd_stein #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start8), .i_a(a8), .i_b(b8),
    .o_y(y8), .o_done(done8), .o_error(error8), .o_busy(busy8), .o_iter(iter8)
  );

  gcd_stein #(.WIDTH(16)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_start(start16), .i_a(a16), .i_b(b16),
    .o_y(y16), .o_done(done16), .o_error(error16), .o_busy(busy16), .o_iter(iter16)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int refGcd(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Start one WIDTH=8 operation and wait for done; lat counts edges after acceptance.
  task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b,
                                output int lat, output int busyCycles);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    lat = 0; busyCycles = 0;
    while (done8 !== 1'b1 && lat < 200) begin
      if (busy8 === 1'b1) busyCycles++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic applyStimulus16(input logic [15:0] a, input logic [15:0] b, output int lat);
    @(negedge clk);
    start16 = 1'b1; a16 = a; b16 = b;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    lat = 0;
    while (done16 !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    assertCount++; if (y8 !== 8'd0)    begin failCount++; $display("[TB] FAIL reset_y: got %0d want 0", y8); end
    assertCount++; if (done8 !== 1'b0) begin failCount++; $display("[TB] FAIL reset_done: got %b want 0", done8); end
    assertCount++; if (error8 !== 1'b0) begin failCount++; $display("[TB] FAIL reset_error: got %b want 0", error8); end
    assertCount++; if (busy8 !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %b want 0", busy8); end
    assertCount++; if (iter8 !== 6'd0) begin failCount++; $display("[TB] FAIL reset_iter: got %0d want 0", iter8); end
    assertCount++; if (y16 !== 16'd0)  begin failCount++; $display("[TB] FAIL reset_y16: got %0d want 0", y16); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] va [4] = '{8'd6, 8'd5, 8'd12, 8'd1};
    logic [7:0] vb [4] = '{8'd21, 8'd15, 8'd18, 8'd255};
    logic [7:0] vy [4] = '{8'd3, 8'd5, 8'd6, 8'd1};
    int         vi [4] = '{6, 3, 5, 15};
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      applyStimulus8(va[i], vb[i], lat, bc);
      assertCount++; if (y8 !== vy[i]) begin failCount++; $display("[TB] FAIL basic_y[%0d]: got %0d want %0d", i, y8, vy[i]); end
      assertCount++; if (error8 !== 1'b0) begin failCount++; $display("[TB] FAIL basic_error[%0d]: got %b want 0", i, error8); end
      assertCount++; if (iter8 !== 6'(vi[i])) begin failCount++; $display("[TB] FAIL basic_iter[%0d]: got %0d want %0d", i, iter8, vi[i]); end
      assertCount++; if (lat !== vi[i]) begin failCount++; $display("[TB] FAIL basic_latency[%0d]: got %0d want %0d", i, lat, vi[i]); end
      assertCount++; if (bc !== vi[i]) begin failCount++; $display("[TB] FAIL basic_busy[%0d]: got %0d want %0d", i, bc, vi[i]); end
      @(negedge clk);
      assertCount++; if (done8 !== 1'b0) begin failCount++; $display("[TB] FAIL basic_done_pulse[%0d]: got %b want 0", i, done8); end
      assertCount++; if (y8 !== vy[i]) begin failCount++; $display("[TB] FAIL basic_y_hold[%0d]: got %0d want %0d", i, y8, vy[i]); end
    end
  endtask

  task automatic test_zero();
    logic [7:0] va [3] = '{8'd0, 8'd17, 8'd0};
    logic [7:0] vb [3] = '{8'd15, 8'd0, 8'd0};
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      applyStimulus8(va[i], vb[i], lat, bc);
      assertCount++; if (y8 !== 8'd0) begin failCount++; $display("[TB] FAIL zero_y[%0d]: got %0d want 0", i, y8); end
      assertCount++; if (error8 !== 1'b1) begin failCount++; $display("[TB] FAIL zero_error[%0d]: got %b want 1", i, error8); end
      assertCount++; if (iter8 !== 6'd0) begin failCount++; $display("[TB] FAIL zero_iter[%0d]: got %0d want 0", i, iter8); end
      assertCount++; if (lat !== 0) begin failCount++; $display("[TB] FAIL zero_latency[%0d]: got %0d want 0", i, lat); end
      assertCount++; if (bc !== 0) begin failCount++; $display("[TB] FAIL zero_busy[%0d]: got %0d want 0", i, bc); end
      @(negedge clk);
      assertCount++; if (done8 !== 1'b0) begin failCount++; $display("[TB] FAIL zero_done_pulse[%0d]: got %b want 0", i, done8); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    applyStimulus8(8'd6, 8'd21, lat, bc);
    assertCount++; if (y8 !== 8'd3) begin failCount++; $display("[TB] FAIL b2b_first_y: got %0d want 3", y8); end
    start8 = 1'b1; a8 = 8'd5; b8 = 8'd15;
    @(posedge clk);
    @(negedge clk);
    assertCount++; if (busy8 !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_busy: got %b want 1", busy8); end
    assertCount++; if (y8 !== 8'd3) begin failCount++; $display("[TB] FAIL b2b_first_hold: got %0d want 3", y8); end
    a8 = 8'd1; b8 = 8'd255;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    while (done8 !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    assertCount++; if (lat !== 3) begin failCount++; $display("[TB] FAIL b2b_latency: got %0d want 3", lat); end
    assertCount++; if (y8 !== 8'd5) begin failCount++; $display("[TB] FAIL b2b_second_y: got %0d want 5", y8); end
    assertCount++; if (iter8 !== 6'd3) begin failCount++; $display("[TB] FAIL b2b_second_iter: got %0d want 3", iter8); end
    @(negedge clk);
    assertCount++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_no_queue: got busy=%b done=%b want 0/0", busy8, done8); end
  endtask

  task automatic test_reset_mid_calc();
    int lat, bc;
    bit sawDone;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd1; b8 = 8'd255;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    assertCount++; if (busy8 !== 1'b1) begin failCount++; $display("[TB] FAIL midrst_busy_before: got %b want 1", busy8); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    assertCount++; if (y8 !== 8'd0 || iter8 !== 6'd0) begin failCount++; $display("[TB] FAIL midrst_y_iter: got y=%0d iter=%0d want 0/0", y8, iter8); end
    assertCount++; if (busy8 !== 1'b0 || done8 !== 1'b0 || error8 !== 1'b0) begin failCount++; $display("[TB] FAIL midrst_flags: got busy=%b done=%b err=%b want 0", busy8, done8, error8); end
    sawDone = 1'b0;
    repeat (20) begin
      if (done8 === 1'b1) sawDone = 1'b1;
      @(negedge clk);
    end
    assertCount++; if (sawDone !== 1'b0) begin failCount++; $display("[TB] FAIL midrst_no_done: got %b want 0", sawDone); end
    applyStimulus8(8'd6, 8'd21, lat, bc);
    assertCount++; if (y8 !== 8'd3) begin failCount++; $display("[TB] FAIL midrst_after_y: got %0d want 3", y8); end
    assertCount++; if (lat !== 6) begin failCount++; $display("[TB] FAIL midrst_after_latency: got %0d want 6", lat); end
  endtask

  task automatic test_width16();
    logic [15:0] va [3] = '{16'd65535, 16'd48, 16'd40000};
    logic [15:0] vb [3] = '{16'd65535, 16'd36, 16'd30000};
    logic [15:0] vy [3] = '{16'd65535, 16'd12, 16'd10000};
    int lat, r;
    for (int i = 0; i < 3; i++) begin
      applyStimulus16(va[i], vb[i], lat);
      r = refGcd(int'(va[i]), int'(vb[i]));
      assertCount++; if (done16 !== 1'b1) begin failCount++; $display("[TB] FAIL w16_done[%0d]: got %b want 1 (timeout)", i, done16); end
      assertCount++; if (y16 !== vy[i]) begin failCount++; $display("[TB] FAIL w16_y[%0d]: got %0d want %0d", i, y16, vy[i]); end
      assertCount++; if (int'(y16) !== r) begin failCount++; $display("[TB] FAIL w16_ref[%0d]: got %0d want %0d", i, y16, r); end
      assertCount++; if (error16 !== 1'b0) begin failCount++; $display("[TB] FAIL w16_error[%0d]: got %b want 0", i, error16); end
      assertCount++; if (int'(iter16) !== lat) begin failCount++; $display("[TB] FAIL w16_iter_latency[%0d]: got iter=%0d lat=%0d", i, iter16, lat); end
    end
    applyStimulus16(16'd65535, 16'd65535, lat);
    assertCount++; if (iter16 !== 7'd1) begin failCount++; $display("[TB] FAIL w16_iter_equal: got %0d want 1", iter16); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_back_to_back();
    test_reset_mid_calc();
    test_width16();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
